csi_packet_parser: RTL and testbench

- Parses CSI-2 packets from the byte-aligned, lane-merged 32-bit word stream out of the D-PHY lane aligner.
- Decodes and ECC-checks the 32-bit packet header and turns short packets into frame and line timing.
- Strips headers and footers from long packets of the selected data type and virtual channel.
- Forwards the bare RAW10 payload words to the RAW10 unpacker with frame and line sync levels.

---
 rtl/csi_packet_parser.sv | 172 +++++++++++++++++
 tb/tb_csi_packet_parser.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/csi_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module      : csi_packet_parser
//  Description : CSI-2 packet parser for a lane-merged 32-bit word stream.
//                Decodes and ECC-checks packet headers, turns FS/FE short
//                packets into frame timing, and forwards the payload of
//                long packets of one data type / virtual channel as bare
//                words with byte enables and line sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module csi_packet_parser #(
    parameter logic [1:0] VC_SEL    = 2'd0,
    parameter logic [5:0] DATA_TYPE = 6'h2B,
    parameter bit         ECC_CHECK = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    input  logic        pkt_start_i,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    output logic [3:0]  byte_en_o,
    output logic        last_o,
    output logic        fsync_o,
    output logic        lsync_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        ecc_err_o,
    output logic        trunc_err_o
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    localparam logic [5:0] c_DT_FS        = 6'h00;
    localparam logic [5:0] c_DT_FE        = 6'h01;
    localparam logic [5:0] c_DT_LONG_BASE = 6'h10;

    state_t      state_q;
    logic [15:0] rem_q;
    logic        fwd_q;

    // CSI-2 header Hamming parity over the 24 bits {WC, DI}
    function automatic logic [5:0] calc_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    // Header field decode (only meaningful on a header word)
    logic [7:0]  w_di;
    logic [1:0]  w_vc;
    logic [5:0]  w_dt;
    logic [15:0] w_wc;
    logic [7:0]  w_ecc;
    logic        w_hdr;
    logic        w_ecc_bad;
    logic        w_hdr_ok;
    logic        w_dt_match;

    assign w_di       = word_i[7:0];
    assign w_vc       = w_di[7:6];
    assign w_dt       = w_di[5:0];
    assign w_wc       = {word_i[23:16], word_i[15:8]};
    assign w_ecc      = word_i[31:24];
    assign w_hdr      = word_valid_i && pkt_start_i;
    assign w_ecc_bad  = ECC_CHECK &&
                        ((w_ecc[7:6] != 2'b00) || (calc_ecc({w_wc, w_di}) != w_ecc[5:0]));
    assign w_hdr_ok   = !w_ecc_bad && (w_vc == VC_SEL);
    assign w_dt_match = (w_dt == DATA_TYPE);

    // Byte enables for the final payload word, from the 1..4 bytes remaining
    logic [3:0] w_last_be;
    always_comb begin
        w_last_be = 4'b1111;
        case (rem_q[2:0])
            3'd1:    w_last_be = 4'b0001;
            3'd2:    w_last_be = 4'b0011;
            3'd3:    w_last_be = 4'b0111;
            default: w_last_be = 4'b1111;
        endcase
    end

    // Packet FSM with all outputs registered
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rem_q         <= 16'd0;
            fwd_q         <= 1'b0;
            data_o        <= 32'd0;
            data_valid_o  <= 1'b0;
            byte_en_o     <= 4'd0;
            last_o        <= 1'b0;
            fsync_o       <= 1'b0;
            lsync_o       <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            ecc_err_o     <= 1'b0;
            trunc_err_o   <= 1'b0;
        end else begin
            data_valid_o  <= 1'b0;
            last_o        <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            ecc_err_o     <= 1'b0;
            trunc_err_o   <= 1'b0;
            // Line sync follows the forward flag while a payload is open; it
            // falls the cycle after the last word, once back in IDLE.
            lsync_o       <= (state_q == ST_PAYLOAD) ? fwd_q : 1'b0;

            if (w_hdr) begin
                // A header inside a payload aborts it: no last_o, and lsync
                // stays low for one cycle even if a new forwarded line opens.
                if (state_q == ST_PAYLOAD) begin
                    trunc_err_o <= 1'b1;
                    lsync_o     <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                if (w_ecc_bad) begin
                    ecc_err_o <= 1'b1;
                end
                if (w_hdr_ok) begin
                    if (w_dt < c_DT_LONG_BASE) begin
                        if (w_dt == c_DT_FS) begin
                            fsync_o       <= 1'b1;
                            frame_start_o <= 1'b1;
                        end else if (w_dt == c_DT_FE) begin
                            fsync_o     <= 1'b0;
                            frame_end_o <= 1'b1;
                            lsync_o     <= 1'b0;
                        end
                    end else if (w_wc != 16'd0) begin
                        rem_q   <= w_wc;
                        fwd_q   <= w_dt_match;
                        state_q <= ST_PAYLOAD;
                        if (state_q == ST_IDLE) begin
                            lsync_o <= w_dt_match;
                        end
                    end
                end
            end else if (word_valid_i && (state_q == ST_PAYLOAD)) begin
                data_valid_o <= fwd_q;
                if (fwd_q) begin
                    data_o <= word_i;
                end
                if (rem_q > 16'd4) begin
                    if (fwd_q) begin
                        byte_en_o <= 4'b1111;
                    end
                    rem_q <= rem_q - 16'd4;
                end else begin
                    if (fwd_q) begin
                        byte_en_o <= w_last_be;
                    end
                    last_o  <= fwd_q;
                    rem_q   <= 16'd0;
                    state_q <= ST_IDLE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csi_packet_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csi_packet_parser
//  Description : Directed, table-driven bench for csi_packet_parser with a
//                second instance built without header ECC checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csi_packet_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word_i = 32'd0;
    logic        word_valid_i = 1'b0;
    logic        pkt_start_i = 1'b0;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic [3:0]  byte_en_o;
    logic        last_o, fsync_o, lsync_o, frame_start_o, frame_end_o, ecc_err_o, trunc_err_o;

    logic [31:0] nc_word = 32'd0;
    logic        nc_valid = 1'b0;
    logic        nc_start = 1'b0;
    logic [31:0] nc_data;
    logic        nc_dv;
    logic [3:0]  nc_be;
    logic        nc_last, nc_fsync, nc_lsync, nc_fs, nc_fe, nc_ecc, nc_trunc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csi_packet_parser #(.VC_SEL(2'd0), .DATA_TYPE(6'h2B), .ECC_CHECK(1'b1)) dut (
        .clk_i(clk), .rst_n(rst_n), .word_i(word_i), .word_valid_i(word_valid_i),
        .pkt_start_i(pkt_start_i), .data_o(data_o), .data_valid_o(data_valid_o),
        .byte_en_o(byte_en_o), .last_o(last_o), .fsync_o(fsync_o), .lsync_o(lsync_o),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
        .ecc_err_o(ecc_err_o), .trunc_err_o(trunc_err_o)
    );

    csi_packet_parser #(.VC_SEL(2'd0), .DATA_TYPE(6'h2B), .ECC_CHECK(1'b0)) dut_nc (
        .clk_i(clk), .rst_n(rst_n), .word_i(nc_word), .word_valid_i(nc_valid),
        .pkt_start_i(nc_start), .data_o(nc_data), .data_valid_o(nc_dv),
        .byte_en_o(nc_be), .last_o(nc_last), .fsync_o(nc_fsync), .lsync_o(nc_lsync),
        .frame_start_o(nc_fs), .frame_end_o(nc_fe),
        .ecc_err_o(nc_ecc), .trunc_err_o(nc_trunc)
    );

    // CSI-2 header ECC as parity masks over {WC, DI}
    function automatic logic [7:0] ecc_of(input logic [23:0] d);
        return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
        return {ecc_of({wc, di}), wc, di};
    endfunction

    typedef struct {
        logic [31:0] w;
        logic        vld;
        logic        st;
        logic [7:0]  flags;   // {dv, last, fsync, lsync, fs, fe, ecc, trunc}
        logic [3:0]  be;
        logic [31:0] d;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] w, input logic vld, input logic st,
                                input logic dv, input logic [3:0] be, input logic lst,
                                input logic fsy, input logic lsy, input logic fs,
                                input logic fe, input logic ecc, input logic tr,
                                input logic [31:0] d);
        vec_t v;
        v.w = w; v.vld = vld; v.st = st;
        v.flags = {dv, lst, fsy, lsy, fs, fe, ecc, tr};
        v.be = be; v.d = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] w, input logic v, input logic s);
        @(negedge clk);
        word_i = w; word_valid_i = v; pkt_start_i = s;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nc(input logic [31:0] w, input logic v, input logic s);
        @(negedge clk);
        nc_word = w; nc_valid = v; nc_start = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {data_valid_o, last_o, fsync_o, lsync_o, frame_start_o,
                frame_end_o, ecc_err_o, trunc_err_o};
    endfunction

    function automatic logic [7:0] obs_nc();
        return {nc_dv, nc_last, nc_fsync, nc_lsync, nc_fs, nc_fe, nc_ecc, nc_trunc};
    endfunction

    vec_t tbl[$];

    initial begin
        // columns: word, valid, start | dv, be, last, fsync, lsync, fs, fe, ecc, trunc, data
        tbl.push_back(mk(32'h01000000,     1,1, 0,4'h0,0, 0,0, 0,0,1,0, 32'h0)); // bad ECC FS
        tbl.push_back(mk(32'h0,            0,0, 0,4'h0,0, 0,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(32'h00000000,     1,1, 0,4'h0,0, 1,0, 1,0,0,0, 32'h0)); // FS
        tbl.push_back(mk(32'h0,            0,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(hdr(8'h01,16'd0), 1,1, 0,4'h0,0, 0,0, 0,1,0,0, 32'h0)); // FE
        tbl.push_back(mk(32'h00000000,     1,1, 0,4'h0,0, 1,0, 1,0,0,0, 32'h0)); // FS
        tbl.push_back(mk(hdr(8'h2B,16'd10),1,1, 0,4'h0,0, 1,1, 0,0,0,0, 32'h0)); // RAW10 WC=10
        tbl.push_back(mk(32'hA0010203,     1,0, 1,4'hF,0, 1,1, 0,0,0,0, 32'hA0010203));
        tbl.push_back(mk(32'hA1040506,     1,0, 1,4'hF,0, 1,1, 0,0,0,0, 32'hA1040506));
        tbl.push_back(mk(32'hA2070809,     1,0, 1,4'h3,1, 1,1, 0,0,0,0, 32'hA2070809));
        tbl.push_back(mk(32'h0,            0,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(hdr(8'h2C,16'd8), 1,1, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0)); // other DT
        tbl.push_back(mk(32'h55555555,     1,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(32'h66666666,     1,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(hdr(8'h01,16'd0), 1,1, 0,4'h0,0, 0,0, 0,1,0,0, 32'h0)); // FE, no trunc
        tbl.push_back(mk(32'h00000000,     1,1, 0,4'h0,0, 1,0, 1,0,0,0, 32'h0)); // FS
        tbl.push_back(mk(hdr(8'h6B,16'd8), 1,1, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0)); // VC=1
        tbl.push_back(mk(32'h12345678,     1,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(32'h9ABCDEF0,     1,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(hdr(8'h2B,16'd20),1,1, 0,4'h0,0, 1,1, 0,0,0,0, 32'h0)); // WC=20
        tbl.push_back(mk(32'hC0C0C0C0,     1,0, 1,4'hF,0, 1,1, 0,0,0,0, 32'hC0C0C0C0));
        tbl.push_back(mk(32'hC1C1C1C1,     1,0, 1,4'hF,0, 1,1, 0,0,0,0, 32'hC1C1C1C1));
        tbl.push_back(mk(32'h00000000,     1,1, 0,4'h0,0, 1,0, 1,0,0,1, 32'h0)); // truncating FS
        tbl.push_back(mk(32'hDEADBEEF,     1,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(hdr(8'h2B,16'd4), 1,1, 0,4'h0,0, 1,1, 0,0,0,0, 32'h0)); // WC=4
        tbl.push_back(mk(32'hE0E1E2E3,     1,0, 1,4'hF,1, 1,1, 0,0,0,0, 32'hE0E1E2E3));
        tbl.push_back(mk(32'hCCCCCCCC,     1,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0)); // CRC word
        tbl.push_back(mk(hdr(8'h2B,16'd1), 1,1, 0,4'h0,0, 1,1, 0,0,0,0, 32'h0)); // WC=1
        tbl.push_back(mk(32'h777777F1,     1,0, 1,4'h1,1, 1,1, 0,0,0,0, 32'h777777F1));
        tbl.push_back(mk(32'h0,            0,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(hdr(8'h2B,16'd0), 1,1, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0)); // WC=0
        tbl.push_back(mk(32'h88888888,     1,0, 0,4'h0,0, 1,0, 0,0,0,0, 32'h0));
        tbl.push_back(mk(32'h40000000,     1,1, 0,4'h0,0, 1,0, 0,0,1,0, 32'h0)); // ECC[7:6]!=0
        tbl.push_back(mk(hdr(8'h01,16'd0), 1,1, 0,4'h0,0, 0,0, 0,1,0,0, 32'h0)); // FE

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {obs(), byte_en_o, data_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors: one registered cycle per row
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].w, tbl[i].vld, tbl[i].st);
            if (tbl[i].flags[7])
                chk($sformatf("row%0d", i), {obs(), byte_en_o, data_o},
                    {tbl[i].flags, tbl[i].be, tbl[i].d});
            else
                chk($sformatf("row%0d", i), {56'd0, obs()}, {56'd0, tbl[i].flags});
        end
        drive(32'h0, 0, 0);

        // Asynchronous reset in the middle of a forwarded payload
        drive(32'h00000000, 1, 1);
        drive(hdr(8'h2B, 16'd20), 1, 1);
        drive(32'h11111111, 1, 0);
        chk("pre_reset_dv", {obs(), byte_en_o, data_o}, {8'b1011_0000, 4'hF, 32'h11111111});
        @(negedge clk);
        word_i = 32'h22222222; word_valid_i = 1'b1; pkt_start_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_reset_zero", {obs(), byte_en_o, data_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_word0", {56'd0, obs()}, 64'd0);
        drive(32'h33333333, 1, 0);
        chk("post_reset_word1", {56'd0, obs()}, 64'd0);
        drive(32'h00000000, 1, 1);
        chk("post_reset_fs", {56'd0, obs()}, {56'd0, 8'b0010_1000});
        drive(32'h0, 0, 0);

        // Instance without ECC checking: corrupted ECC byte is ignored
        drive_nc(32'h01000000, 1, 1);
        chk("nc_fs_bad_ecc", {56'd0, obs_nc()}, {56'd0, 8'b0010_1000});
        drive_nc(32'h00000001, 1, 1);
        chk("nc_fe", {56'd0, obs_nc()}, {56'd0, 8'b0000_0100});
        drive_nc(32'h00000A2B, 1, 1);
        chk("nc_long_hdr", {56'd0, obs_nc()}, {56'd0, 8'b0001_0000});
        drive_nc(32'hB0B0B0B0, 1, 0);
        drive_nc(32'hB1B1B1B1, 1, 0);
        drive_nc(32'hB2B2B2B2, 1, 0);
        chk("nc_last_word", {obs_nc(), nc_be, nc_data}, {8'b1101_0000, 4'h3, 32'hB2B2B2B2});
        drive_nc(32'h0, 0, 0);
        chk("nc_lsync_fall", {56'd0, obs_nc()}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
